// File: rtl/fuzz_mix_pkg.sv
// Shared constants for the fuzz_mix_core datapath: output field map and LFSR parameters.
package fuzz_mix_pkg;

  localparam int unsigned I_LSB = 0;
  localparam int unsigned I_W   = 2;
  localparam int unsigned E_LSB = 2;
  localparam int unsigned E_W   = 8;
  localparam int unsigned H_LSB = 10;
  localparam int unsigned H_W   = 12;
  localparam int unsigned G_LSB = 22;
  localparam int unsigned G_W   = 18;
  localparam int unsigned D_LSB = 40;
  localparam int unsigned D_W   = 18;
  localparam int unsigned A_LSB = 58;
  localparam int unsigned A_W   = 21;
  localparam int unsigned C_LSB = 79;
  localparam int unsigned C_W   = 20;
  localparam int unsigned K_LSB = 99;
  localparam int unsigned K_W   = 26;
  localparam int unsigned B_LSB = 125;
  localparam int unsigned B_W   = 30;
  localparam int unsigned F_LSB = 155;
  localparam int unsigned F_W   = 32;
  localparam int unsigned L_LSB = 187;
  localparam int unsigned L_W   = 46;

  localparam int unsigned Y_W     = 233;
  localparam int unsigned IN_BITS = 76;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

endpackage

// File: rtl/fuzz_mix_lfsr32.sv
// Free-running 32-bit Galois LFSR; advances every cycle while out of reset.
module fuzz_mix_lfsr32 import fuzz_mix_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] out
);

  logic [31:0] nxt;

  always_comb begin
    nxt = (out >> 1) ^ (out[0] ? LFSR_POLY : 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= LFSR_SEED;
    else        out <= nxt;
  end

endmodule

// File: rtl/fuzz_mix_core.sv
// Registered mixed-arithmetic fuzz target: eleven fields computed from five
// operand buses and packed onto one wide output.
module fuzz_mix_core import fuzz_mix_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [17:0]    wire4,
  input  logic [11:0]    wire3,
  input  logic [19:0]    wire2,
  input  logic [17:0]    wire1,
  input  logic [7:0]     wire0,
  output logic [Y_W-1:0] y
);

  logic [A_W-1:0] a_q, a_nxt;
  logic [B_W-1:0] b_q, b_nxt;
  logic [C_W-1:0] c_q, c_nxt;
  logic [D_W-1:0] d_q, d_nxt;
  logic [E_W-1:0] e_q, e_nxt;
  logic [F_W-1:0] f_q;
  logic [G_W-1:0] g_q, g_nxt;
  logic [H_W-1:0] h_q, h_nxt;
  logic [K_W-1:0] k_q, k_nxt;
  logic [L_W-1:0] l_q, l_nxt;

  logic [IN_BITS-1:0] all_in;
  logic [3:0]         rot_n;
  logic [2*H_W-1:0]   rot_wide;

  // Next values for every registered field
  always_comb begin
    all_in   = {wire4, wire3, wire2, wire1, wire0};
    a_nxt    = {{3{wire4[17]}}, wire4} + {wire2[19], wire2} + {{13{wire0[7]}}, wire0};
    b_nxt    = B_W'(wire1) * B_W'(wire3);
    c_nxt    = wire2 ^ {wire3, wire0};
    d_nxt    = d_q + wire4;
    k_nxt    = {{8{wire4[17]}}, wire4} * {{18{wire0[7]}}, wire0};
    l_nxt    = {l_q[L_W-2:0], l_q[L_W-1]} ^ {wire2, wire3, wire1[17:4]};
    g_nxt    = ($signed(wire4) >= $signed(wire2[19:2])) ? wire4 : wire2[19:2];

    e_nxt = '0;
    for (int unsigned i = 0; i < IN_BITS; i++) begin
      e_nxt = e_nxt + E_W'(all_in[i]);
    end

    // Amounts 12..15 fold back into 0..3 so the rotate stays within one turn
    rot_n    = (wire0[3:0] < 4'd12) ? wire0[3:0] : wire0[3:0] - 4'd12;
    rot_wide = {wire3, wire3} << rot_n;
    h_nxt    = rot_wide[2*H_W-1:H_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      e_q <= '0;
      g_q <= '0;
      h_q <= '0;
      k_q <= '0;
      l_q <= '0;
    end else begin
      a_q <= a_nxt;
      b_q <= b_nxt;
      c_q <= c_nxt;
      d_q <= d_nxt;
      e_q <= e_nxt;
      g_q <= g_nxt;
      h_q <= h_nxt;
      k_q <= k_nxt;
      l_q <= l_nxt;
    end
  end

  fuzz_mix_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (f_q)
  );

  // Flags decode the registered sum directly
  assign y[I_LSB +: I_W] = {a_q[A_W-1], (a_q == '0)};
  assign y[E_LSB +: E_W] = e_q;
  assign y[H_LSB +: H_W] = h_q;
  assign y[G_LSB +: G_W] = g_q;
  assign y[D_LSB +: D_W] = d_q;
  assign y[A_LSB +: A_W] = a_q;
  assign y[C_LSB +: C_W] = c_q;
  assign y[K_LSB +: K_W] = k_q;
  assign y[B_LSB +: B_W] = b_q;
  assign y[F_LSB +: F_W] = f_q;
  assign y[L_LSB +: L_W] = l_q;

endmodule

// File: tb/tb_fuzz_mix_core.sv
// Self-checking bench for fuzz_mix_core using a reference model and scoreboard queue.
module tb_fuzz_mix_core;
  import fuzz_mix_pkg::*;

  logic           clk;
  logic           rst_n;
  logic [17:0]    wire4;
  logic [11:0]    wire3;
  logic [19:0]    wire2;
  logic [17:0]    wire1;
  logic [7:0]     wire0;
  logic [Y_W-1:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  logic [Y_W-1:0] sb[$];
  logic [Y_W-1:0] rst_val;

  // Model state for the accumulating fields
  logic [17:0] m_d;
  logic [31:0] m_f;
  logic [45:0] m_l;

  fuzz_mix_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wire4 (wire4),
    .wire3 (wire3),
    .wire2 (wire2),
    .wire1 (wire1),
    .wire0 (wire0),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic void model_reset();
    m_d = '0;
    m_f = 32'h0000_0001;
    m_l = '0;
  endfunction

  function automatic logic [Y_W-1:0] model_out(input logic [17:0] i4, input logic [11:0] i3,
                                               input logic [19:0] i2, input logic [17:0] i1,
                                               input logic [7:0] i0);
    logic [Y_W-1:0]   r;
    logic [31:0]      s;
    longint           pk;
    longint unsigned  pb;
    logic [63:0]      pkv;
    logic [63:0]      pbv;
    logic [11:0]      h;
    logic [17:0]      g;
    logic [75:0]      bits;
    int               n;
    int               s4;
    int               s2;
    logic [31:0]      f_n;
    r    = '0;
    s    = 32'($signed(i4) + $signed(i2) + $signed(i0));
    pk   = longint'($signed(i4)) * longint'($signed(i0));
    pkv  = pk;
    pb   = longint'(i1) * longint'(i3);
    pbv  = pb;
    bits = {i4, i3, i2, i1, i0};
    n    = int'(i0[3:0]);
    if (n >= 12) n = n - 12;
    h = '0;
    for (int i = 0; i < 12; i++) h[(i + n) % 12] = i3[i];
    s4 = $signed(i4);
    s2 = $signed(i2[19:2]);
    g  = (s4 >= s2) ? i4 : i2[19:2];
    f_n = {1'b0, m_f[31:1]} ^ (m_f[0] ? 32'h8020_0003 : 32'h0);
    r[A_LSB +: A_W] = s[20:0];
    r[0]            = (s[20:0] == 21'h0);
    r[1]            = s[20];
    r[E_LSB +: E_W] = 8'($countones(bits));
    r[H_LSB +: H_W] = h;
    r[G_LSB +: G_W] = g;
    r[D_LSB +: D_W] = m_d + i4;
    r[C_LSB +: C_W] = i2 ^ {i3, i0};
    r[K_LSB +: K_W] = pkv[25:0];
    r[B_LSB +: B_W] = pbv[29:0];
    r[F_LSB +: F_W] = f_n;
    r[L_LSB +: L_W] = {m_l[44:0], m_l[45]} ^ {i2, i3, i1[17:4]};
    return r;
  endfunction

  // Drive one cycle of operands, push the predicted result, advance past the edge
  task automatic step(input logic [17:0] i4, input logic [11:0] i3, input logic [19:0] i2,
                      input logic [17:0] i1, input logic [7:0] i0);
    logic [Y_W-1:0] e;
    wire4 = i4; wire3 = i3; wire2 = i2; wire1 = i1; wire0 = i0;
    e = model_out(i4, i3, i2, i1, i0);
    sb.push_back(e);
    m_d = e[D_LSB +: D_W];
    m_f = e[F_LSB +: F_W];
    m_l = e[L_LSB +: L_W];
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    wire4 = 18'($urandom); wire3 = 12'($urandom); wire2 = 20'($urandom);
    wire1 = 18'($urandom); wire0 = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sb.delete();
  endtask

  task automatic test_reset();
    logic [Y_W-1:0] e;
    rst_n = 1'b0;
    wire4 = 18'h2A5A5; wire3 = 12'hC3C; wire2 = 20'h9F0E1; wire1 = 18'h15555; wire0 = 8'h96;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (y !== rst_val) begin n_fail++; $display("FAIL reset_value got %h exp %h", y, rst_val); end
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    step('0, '0, '0, '0, '0);
    e = sb.pop_front();
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL first_edge got %h exp %h", y, e); end
    n_checks++;
    if (y[F_LSB +: F_W] !== 32'h8020_0003) begin
      n_fail++; $display("FAIL first_lfsr got %h exp 80200003", y[F_LSB +: F_W]);
    end
    n_checks++;
    if (y[I_LSB +: I_W] !== 2'b01) begin
      n_fail++; $display("FAIL first_flags got %b exp 01", y[I_LSB +: I_W]);
    end
    n_checks++;
    if (y[232:187] !== 46'h0 || y[154:2] !== 153'h0) begin
      n_fail++; $display("FAIL first_zero_fields got %h", y);
    end
  endtask

  task automatic test_sum_flags();
    logic [Y_W-1:0] e;
    step(18'h00010, 12'h000, 20'h00005, 18'h00000, 8'hFD);
    e = sb.pop_front();
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL sum_pos_full got %h exp %h", y, e); end
    n_checks++;
    if (y[A_LSB +: A_W] !== 21'h000012) begin
      n_fail++; $display("FAIL sum_pos got %h exp 000012", y[A_LSB +: A_W]);
    end
    n_checks++;
    if (y[I_LSB +: I_W] !== 2'b00) begin
      n_fail++; $display("FAIL flags_pos got %b exp 00", y[I_LSB +: I_W]);
    end
    step(18'h3FFF0, 12'h000, 20'h00000, 18'h00000, 8'h00);
    e = sb.pop_front();
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL sum_neg_full got %h exp %h", y, e); end
    n_checks++;
    if (y[A_LSB +: A_W] !== 21'h1FFFF0) begin
      n_fail++; $display("FAIL sum_neg got %h exp 1ffff0", y[A_LSB +: A_W]);
    end
    n_checks++;
    if (y[I_LSB +: I_W] !== 2'b10) begin
      n_fail++; $display("FAIL flags_neg got %b exp 10", y[I_LSB +: I_W]);
    end
  endtask

  task automatic test_products();
    logic [Y_W-1:0] e;
    step(18'h00000, 12'hFFF, 20'h00000, 18'h3FFFF, 8'h00);
    e = sb.pop_front();
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL umul_full got %h exp %h", y, e); end
    n_checks++;
    if (y[B_LSB +: B_W] !== 30'h3FFBF001) begin
      n_fail++; $display("FAIL umul got %h exp 3ffbf001", y[B_LSB +: B_W]);
    end
    step(18'h3FFFE, 12'h000, 20'h00000, 18'h00000, 8'h7F);
    e = sb.pop_front();
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL smul_full got %h exp %h", y, e); end
    n_checks++;
    if (y[K_LSB +: K_W] !== 26'h3FFFF02) begin
      n_fail++; $display("FAIL smul got %h exp 3ffff02", y[K_LSB +: K_W]);
    end
  endtask

  task automatic test_rotate_max_popcount();
    logic [Y_W-1:0] e;
    step(18'h0, 12'h801, 20'h0, 18'h0, 8'h01);
    e = sb.pop_front();
    n_checks++;
    if (y[H_LSB +: H_W] !== 12'h003) begin
      n_fail++; $display("FAIL rot1 got %h exp 003", y[H_LSB +: H_W]);
    end
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL rot1_full got %h exp %h", y, e); end
    step(18'h0, 12'h801, 20'h0, 18'h0, 8'h0D);
    e = sb.pop_front();
    n_checks++;
    if (y[H_LSB +: H_W] !== 12'h003) begin
      n_fail++; $display("FAIL rot13 got %h exp 003", y[H_LSB +: H_W]);
    end
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL rot13_full got %h exp %h", y, e); end
    step(18'h3FFFF, 12'hFFF, 20'hFFFFF, 18'h3FFFF, 8'hFF);
    e = sb.pop_front();
    n_checks++;
    if (y[E_LSB +: E_W] !== 8'h4C) begin
      n_fail++; $display("FAIL popcount got %h exp 4c", y[E_LSB +: E_W]);
    end
    n_checks++;
    if (y[G_LSB +: G_W] !== 18'h3FFFF) begin
      n_fail++; $display("FAIL max_tie got %h exp 3ffff", y[G_LSB +: G_W]);
    end
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL ones_full got %h exp %h", y, e); end
  endtask

  task automatic test_accumulator();
    logic [Y_W-1:0] e;
    apply_reset();
    step(18'h20000, 12'h0, 20'h0, 18'h0, 8'h0);
    e = sb.pop_front();
    n_checks++;
    if (y[D_LSB +: D_W] !== 18'h20000) begin
      n_fail++; $display("FAIL acc1 got %h exp 20000", y[D_LSB +: D_W]);
    end
    step(18'h20000, 12'h0, 20'h0, 18'h0, 8'h0);
    e = sb.pop_front();
    n_checks++;
    if (y[D_LSB +: D_W] !== 18'h00000) begin
      n_fail++; $display("FAIL acc_wrap got %h exp 00000", y[D_LSB +: D_W]);
    end
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL acc_full got %h exp %h", y, e); end
  endtask

  task automatic test_checksum_async_reset();
    logic [Y_W-1:0] e;
    apply_reset();
    step(18'h0, 12'h0, 20'hFFFFF, 18'h0, 8'h0);
    e = sb.pop_front();
    n_checks++;
    if (y[L_LSB +: L_W] !== {20'hFFFFF, 26'h0}) begin
      n_fail++; $display("FAIL checksum got %h exp %h", y[L_LSB +: L_W], {20'hFFFFF, 26'h0});
    end
    n_checks++;
    if (y !== e) begin n_fail++; $display("FAIL checksum_full got %h exp %h", y, e); end
    // Drop reset between edges; output must clear before the next posedge
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (y !== rst_val) begin n_fail++; $display("FAIL async_reset got %h exp %h", y, rst_val); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [Y_W-1:0] e;
    for (int i = 0; i < 300; i++) begin
      step(18'($urandom), 12'($urandom), 20'($urandom), 18'($urandom), 8'($urandom));
      e = sb.pop_front();
      n_checks++;
      if (y !== e) begin n_fail++; $display("FAIL random_%0d got %h exp %h", i, y, e); end
    end
  endtask

  initial begin
    rst_val      = '0;
    rst_val[0]   = 1'b1;
    rst_val[155] = 1'b1;
    rst_n = 1'b0;
    wire4 = '0; wire3 = '0; wire2 = '0; wire1 = '0; wire0 = '0;
    model_reset();
    test_reset();
    test_sum_flags();
    test_products();
    test_rotate_max_popcount();
    test_accumulator();
    test_checksum_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_mix_core.md
Name: fuzz_mix_core

Overview:
Registered mixed-arithmetic datapath used as a fuzz/equivalence target.
- Each rising clock edge it samples five operand buses.
- It computes eleven independent arithmetic, logic and state fields from them.
- It presents all fields concatenated on one 233-bit output.
- It sits at the top of the fuzz harness, fed directly by stimulus registers.

Parameters:
None. All widths are fixed; constants live in the package.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wire4  in  18  signed operand
wire3  in  12  unsigned operand
wire2  in  20  signed operand
wire1  in  18  unsigned operand
wire0  in  8  signed operand
y  out  233  concatenated result fields, see bit map

Behaviour:
- One clock; reset is asynchronous and active-low.
- All state is in flops that clear immediately when rst_n falls.
- Flops reset to 0, except the LFSR, which resets to 32'h0000_0001.
- Reset value of y: bit 155 = 1 (LFSR seed), bit 0 = 1 (zero flag), all other bits 0. That is 233'h1 | (1 << 155).
- Fields A to L are registered from the inputs present at a posedge, so latency is 1 cycle. Flags I are combinational from registered A.
- All arithmetic truncates to the field width (wrap-around); there is no saturation.

Bit map of y:
- y[1:0] I: I[0] = (A == 0), I[1] = A[20] (A negative).
- y[9:2] E: population count of all 76 input bits, zero-extended to 8 bits.
- y[21:10] H: wire3 rotated left by n.
  - n = wire0[3:0] if below 12, else wire0[3:0] − 12.
- y[39:22] G: the signed maximum of wire4 and wire2[19:2] (both 18-bit signed). On a tie, output wire4.
- y[57:40] D: 18-bit accumulator, D <= D + wire4 (signed, wraps).
- y[78:58] A: sext21(wire2) + sext21(wire4) + sext21(wire0).
- y[98:79] C: wire2 ^ {wire3, wire0}.
- y[124:99] K: signed product wire4 * wire0, 26 bits.
- y[154:125] B: unsigned product wire1 * wire3, 30 bits.
- y[186:155] F: 32-bit Galois LFSR, advanced every cycle while out of reset.
  - Next state: (F >> 1) ^ (F[0] ? 32'h8020_0003 : 0).
  - Sequence from seed: 0000_0001, 8020_0003, C030_0002, …
- y[232:187] L: 46-bit checksum.
  - L <= {L[44:0], L[45]} ^ {wire2, wire3, wire1[17:4]}.
- Stateful fields D, F and L keep evolving every cycle; there is no enable.
- Reset asserted mid-run returns y to its reset value asynchronously. The first posedge after release resumes from the reset state.

Decomposition:
- Package fuzz_mix_pkg holds:
  - field LSB/width localparams for A–L and I;
  - LFSR_POLY = 32'h8020_0003 and LFSR_SEED = 32'h1;
  - total output width 233.
- One natural sub-module: fuzz_mix_lfsr32 (clk, rst_n, out[31:0]), which holds the LFSR with its seed and polynomial.
- Rotate, popcount, max and checksum stay inline.

Test Plan:
- Reset: hold rst_n = 0 with arbitrary inputs → y == (1<<155)|1. Release, one posedge with zero inputs → F = 32'h8020_0003, I[0] = 1, all other fields 0.
- Sum and flags: wire4 = 18'h00010, wire2 = 20'h00005, wire0 = 8'hFD → after one edge A = 21'h000012, I = 2'b00. Then wire4 = 18'h3FFF0, wire2 = 0, wire0 = 0 → A = 21'h1FFFF0, I = 2'b10.
- Products: wire1 = 18'h3FFFF, wire3 = 12'hFFF → B = 30'h3FFBF001. Separately, wire4 = 18'h3FFFE, wire0 = 8'h7F → K = 26'h3FFFF02.
- Rotate, max and popcount:
  - wire3 = 12'h801, wire0[3:0] = 1 → H = 12'h003.
  - wire0[3:0] = 13 → H = 12'h003.
  - All inputs all-ones → E = 8'h4C and G = 18'h3FFFF (tie → wire4).
- Accumulator wrap: after reset, drive wire4 = 18'h20000 for two edges → D = 18'h20000, then 18'h00000.
- Checksum and async reset: wire2 = 20'hFFFFF, other inputs 0 → after one edge L = {20'hFFFFF, 26'h0}. Drop rst_n between clock edges → y returns to reset value before the next edge.
